// File: rtl/ahb_apb_pkg.sv
// Shared AHB/APB encodings and the bridge state type.
package ahb_apb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HSIZE_DWORD   = 3'b011;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WDATA  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_ERR1   = 3'd4,
        ST_ERR2   = 3'd5
    } bridge_state_e;

    // The APB side is 32 bits wide, so anything wider than a word is refused.
    function automatic logic size_supported(input logic [2:0] size);
        return size <= HSIZE_WORD;
    endfunction

endpackage

// File: rtl/ahb2apb_strb.sv
// Byte-strobe decode for an APB write from transfer size and address low bits.
module ahb2apb_strb
    import ahb_apb_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]              addr_lo,
    input  logic [2:0]              size,
    input  logic                    write,
    output logic [DATA_WIDTH/8-1:0] strb
);

    localparam int STRB_W = DATA_WIDTH / 8;

    // Reads never drive strobes; halfwords align to the halfword lane.
    always_comb begin
        strb = '0;
        if (write) begin
            case (size)
                HSIZE_BYTE: strb = STRB_W'(1) << addr_lo;
                HSIZE_HALF: strb = STRB_W'(3) << {addr_lo[1], 1'b0};
                HSIZE_WORD: strb = '1;
                default:    strb = '0;
            endcase
        end
    end

endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB4 master bridge; one transfer in flight at a time.
//
// state  | meaning
// IDLE   | ready for a new AHB transfer
// WDATA  | AHB write data phase, capturing hwdata
// SETUP  | APB setup cycle (psel, no penable)
// ACCESS | APB access cycle, waiting on pready
// ERR1   | first ERROR response cycle (hreadyout low)
// ERR2   | second ERROR response cycle (hreadyout high)
module ahb2apb_bridge
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    hclk,
    input  logic                    hrst,
    input  logic                    hsel,
    input  logic [ADDR_WIDTH-1:0]   haddr,
    input  logic                    hwrite,
    input  logic [1:0]              htrans,
    input  logic [2:0]              hsize,
    input  logic [DATA_WIDTH-1:0]   hwdata,
    input  logic                    hready,
    output logic                    hreadyout,
    output logic                    hresp,
    output logic [DATA_WIDTH-1:0]   hrdata,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    bridge_state_e           state;
    logic [2:0]              size_q;
    logic [DATA_WIDTH/8-1:0] strb_next;
    logic                    valid_xfer;
    logic                    access_done;
    logic                    access_err;
    logic                    accept;

    assign valid_xfer  = hsel & htrans[1] & hready;
    assign access_done = (state == ST_ACCESS) & pready & ~pslverr;
    assign access_err  = (state == ST_ACCESS) & pready & pslverr;

    // New transfers are taken only where this slave is driving hreadyout high.
    assign accept = valid_xfer &
                    ((state == ST_IDLE) | (state == ST_ERR2) | access_done);

    // Strobes come from the registered address phase so they are ready by SETUP.
    ahb2apb_strb #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_strb (
        .addr_lo (paddr[1:0]),
        .size    (size_q),
        .write   (pwrite),
        .strb    (strb_next)
    );

    // State sequencing and the registered APB address/control/data.
    always_ff @(posedge hclk) begin
        if (hrst) begin
            state  <= ST_IDLE;
            paddr  <= '0;
            pwrite <= 1'b0;
            pwdata <= '0;
            pstrb  <= '0;
            size_q <= '0;
        end else if (accept) begin
            paddr  <= haddr;
            pwrite <= hwrite;
            size_q <= hsize;
            pstrb  <= '0;
            if (!size_supported(hsize)) begin
                state <= ST_ERR1;
            end else if (hwrite) begin
                state <= ST_WDATA;
            end else begin
                state <= ST_SETUP;
            end
        end else begin
            case (state)
                ST_IDLE:   state <= ST_IDLE;
                ST_WDATA: begin
                    pwdata <= hwdata;
                    pstrb  <= strb_next;
                    state  <= ST_SETUP;
                end
                ST_SETUP:  state <= ST_ACCESS;
                ST_ACCESS: begin
                    if (pready) begin
                        state <= pslverr ? ST_ERR2 : ST_IDLE;
                    end
                end
                ST_ERR1:   state <= ST_ERR2;
                ST_ERR2:   state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    assign psel    = (state == ST_SETUP) | (state == ST_ACCESS);
    assign penable = (state == ST_ACCESS);

    // AHB response decode; ACCESS follows pready so completion costs no extra cycle.
    always_comb begin
        hreadyout = 1'b1;
        case (state)
            ST_IDLE:   hreadyout = 1'b1;
            ST_WDATA:  hreadyout = 1'b0;
            ST_SETUP:  hreadyout = 1'b0;
            ST_ACCESS: hreadyout = access_done;
            ST_ERR1:   hreadyout = 1'b0;
            ST_ERR2:   hreadyout = 1'b1;
            default:   hreadyout = 1'b1;
        endcase
    end

    assign hresp  = (state == ST_ERR1) | (state == ST_ERR2) | access_err;
    assign hrdata = (access_done & ~pwrite) ? prdata : '0;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Directed bench for ahb2apb_bridge with hand-computed expectations.
module tb_ahb2apb_bridge;
    import ahb_apb_pkg::*;

    logic        hclk = 1'b0;
    logic        hrst;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_cmp = 0;
    int n_err = 0;

    ahb2apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .hclk(hclk), .hrst(hrst), .hsel(hsel), .haddr(haddr), .hwrite(hwrite),
        .htrans(htrans), .hsize(hsize), .hwdata(hwdata), .hready(hready),
        .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .paddr(paddr),
        .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge hclk);
        #1;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] s);
        hsel   = 1'b1;
        htrans = HTRANS_NONSEQ;
        haddr  = a;
        hwrite = w;
        hsize  = s;
    endtask

    task automatic bus_idle();
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
    endtask

    initial begin
        int n_low;
        hrst = 1'b1; hsel = 1'b0; haddr = '0; hwrite = 1'b0; htrans = HTRANS_IDLE;
        hsize = HSIZE_WORD; hwdata = '0; hready = 1'b1;
        prdata = '0; pready = 1'b1; pslverr = 1'b0;
        cyc(); cyc();
        hrst = 1'b0;
        @(negedge hclk);
        chk("rst_hreadyout", 32'(hreadyout), 32'd1);
        chk("rst_hresp", 32'(hresp), 32'd0);
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_pwrite", 32'(pwrite), 32'd0);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_pstrb", 32'(pstrb), 32'd0);

        // hsel with BUSY: OKAY, no APB activity
        cyc(); hsel = 1'b1; htrans = HTRANS_BUSY; haddr = 32'h4000_0044;
        cyc(); bus_idle();
        @(negedge hclk);
        chk("busy_psel", 32'(psel), 32'd0);
        chk("busy_hready", 32'(hreadyout), 32'd1);

        // Read, pready high
        cyc(); addr_phase(32'h4000_0010, 1'b0, HSIZE_WORD); prdata = 32'hDEAD_BEEF;
        cyc(); bus_idle();
        @(negedge hclk);
        chk("rd_c1_psel", 32'(psel), 32'd1);
        chk("rd_c1_penable", 32'(penable), 32'd0);
        chk("rd_c1_hready", 32'(hreadyout), 32'd0);
        chk("rd_c1_paddr", paddr, 32'h4000_0010);
        chk("rd_c1_pwrite", 32'(pwrite), 32'd0);
        cyc();
        @(negedge hclk);
        chk("rd_c2_penable", 32'(penable), 32'd1);
        chk("rd_c2_hready", 32'(hreadyout), 32'd1);
        chk("rd_c2_hrdata", hrdata, 32'hDEAD_BEEF);
        cyc();
        @(negedge hclk);
        chk("rd_c3_psel", 32'(psel), 32'd0);
        chk("rd_c3_hrdata", hrdata, 32'd0);

        // Byte write at offset 3
        cyc(); addr_phase(32'h4000_0003, 1'b1, HSIZE_BYTE);
        cyc(); bus_idle(); hwdata = 32'h1122_3344;
        @(negedge hclk);
        chk("wr_c1_hready", 32'(hreadyout), 32'd0);
        chk("wr_c1_psel", 32'(psel), 32'd0);
        cyc(); hwdata = 32'hFFFF_FFFF;
        @(negedge hclk);
        chk("wr_c2_psel", 32'(psel), 32'd1);
        chk("wr_c2_penable", 32'(penable), 32'd0);
        chk("wr_c2_hready", 32'(hreadyout), 32'd0);
        chk("wr_c2_pwdata", pwdata, 32'h1122_3344);
        chk("wr_c2_pstrb", 32'(pstrb), 32'h8);
        chk("wr_c2_pwrite", 32'(pwrite), 32'd1);
        cyc();
        @(negedge hclk);
        chk("wr_c3_penable", 32'(penable), 32'd1);
        chk("wr_c3_hready", 32'(hreadyout), 32'd1);
        chk("wr_c3_pwdata", pwdata, 32'h1122_3344);
        chk("wr_c3_pstrb", 32'(pstrb), 32'h8);
        chk("wr_c3_hrdata", hrdata, 32'd0);
        cyc();
        @(negedge hclk);
        chk("wr_c4_psel", 32'(psel), 32'd0);

        // Read with three stalled ACCESS cycles
        cyc(); addr_phase(32'h4000_0024, 1'b0, HSIZE_WORD); pready = 1'b0; prdata = 32'hCAFE_F00D;
        n_low = 0;
        for (int c = 1; c <= 20; c++) begin
            cyc();
            if (c == 1) bus_idle();
            pready = (c >= 5);
            @(negedge hclk);
            chk("stall_paddr", paddr, 32'h4000_0024);
            if (!hreadyout) n_low++;
            if (hreadyout) begin
                chk("stall_hrdata", hrdata, 32'hCAFE_F00D);
                break;
            end
        end
        chk("stall_wait_cycles", 32'(n_low), 32'd4);

        // Write with pslverr
        cyc(); addr_phase(32'h4000_0008, 1'b1, HSIZE_WORD); pready = 1'b1; pslverr = 1'b1;
        cyc(); bus_idle(); hwdata = 32'h0BAD_0BAD;
        cyc();
        cyc();
        @(negedge hclk);
        chk("slverr_a_hresp", 32'(hresp), 32'd1);
        chk("slverr_a_hready", 32'(hreadyout), 32'd0);
        chk("slverr_a_penable", 32'(penable), 32'd1);
        cyc(); pslverr = 1'b0;
        @(negedge hclk);
        chk("slverr_b_hresp", 32'(hresp), 32'd1);
        chk("slverr_b_hready", 32'(hreadyout), 32'd1);
        chk("slverr_b_psel", 32'(psel), 32'd0);
        cyc();
        @(negedge hclk);
        chk("slverr_c_hresp", 32'(hresp), 32'd0);

        // Unsupported size -> ERR1/ERR2, no APB
        cyc(); addr_phase(32'h4000_0000, 1'b0, HSIZE_DWORD);
        cyc(); bus_idle();
        @(negedge hclk);
        chk("size_e1_hresp", 32'(hresp), 32'd1);
        chk("size_e1_hready", 32'(hreadyout), 32'd0);
        chk("size_e1_psel", 32'(psel), 32'd0);
        cyc();
        @(negedge hclk);
        chk("size_e2_hresp", 32'(hresp), 32'd1);
        chk("size_e2_hready", 32'(hreadyout), 32'd1);
        chk("size_e2_psel", 32'(psel), 32'd0);
        cyc();
        @(negedge hclk);
        chk("size_e3_hresp", 32'(hresp), 32'd0);
        chk("size_e3_psel", 32'(psel), 32'd0);

        // Back-to-back read then halfword write
        cyc(); addr_phase(32'h4000_0030, 1'b0, HSIZE_WORD); prdata = 32'h1234_5678;
        cyc(); bus_idle();
        cyc(); addr_phase(32'h4000_0032, 1'b1, HSIZE_HALF);
        @(negedge hclk);
        chk("b2b_rd_hready", 32'(hreadyout), 32'd1);
        chk("b2b_rd_hrdata", hrdata, 32'h1234_5678);
        cyc(); bus_idle(); hwdata = 32'hA5A5_5A5A;
        @(negedge hclk);
        chk("b2b_wdata_hready", 32'(hreadyout), 32'd0);
        chk("b2b_wdata_psel", 32'(psel), 32'd0);
        chk("b2b_wdata_paddr", paddr, 32'h4000_0032);
        cyc();
        @(negedge hclk);
        chk("b2b_setup_psel", 32'(psel), 32'd1);
        chk("b2b_setup_pstrb", 32'(pstrb), 32'hC);
        chk("b2b_setup_pwdata", pwdata, 32'hA5A5_5A5A);
        cyc();
        @(negedge hclk);
        chk("b2b_access_hready", 32'(hreadyout), 32'd1);
        chk("b2b_access_penable", 32'(penable), 32'd1);

        // Reset during ACCESS, with pready rising at the same edge
        cyc(); addr_phase(32'h4000_0050, 1'b0, HSIZE_WORD); pready = 1'b0;
        cyc(); bus_idle();
        cyc(); hrst = 1'b1; pready = 1'b1;
        @(negedge hclk);
        chk("rstx_pre_penable", 32'(penable), 32'd1);
        cyc(); hrst = 1'b0;
        @(negedge hclk);
        chk("rstx_psel", 32'(psel), 32'd0);
        chk("rstx_penable", 32'(penable), 32'd0);
        chk("rstx_hready", 32'(hreadyout), 32'd1);
        chk("rstx_hresp", 32'(hresp), 32'd0);
        chk("rstx_paddr", paddr, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
